ddr_axi_slave_mem: RTL and testbench
====================================

DDR_AXI_SLAVE_MEM -- requirements
Module: ddr_axi_slave_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 49, AXI address width.
REQ-002 SHALL have parameter MEM_AW, default 10, RAM word-address width (depth 2^MEM_AW x 128 bit).
REQ-003 SHALL have parameter ID_W, default 6, AXI ID width.
REQ-004 SHALL have port clk  input  1  single clock for all channels.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports s_axi_awid/awaddr/awlen/awsize/awburst  input  ID_W/ADDR_W/8/3/2  write address.
REQ-007 SHALL have ports s_axi_awvalid input 1, s_axi_awready output 1  AW handshake.
REQ-008 SHALL have ports s_axi_wdata/wstrb/wlast/wvalid input 128/16/1/1, s_axi_wready output 1  write data.
REQ-009 SHALL have ports s_axi_bid/bresp/bvalid output ID_W/2/1, s_axi_bready input 1  write response.
REQ-010 SHALL have ports s_axi_arid/araddr/arlen/arsize/arburst/arvalid input ID_W/ADDR_W/8/3/2/1, s_axi_arready output 1  read address.
REQ-011 SHALL have ports s_axi_rid/rdata/rresp/rlast/rvalid output ID_W/128/2/1/1, s_axi_rready input 1  read data.

Function
REQ-012 SHALL be an AXI4 responder serving one transaction at a time; FSM states IDLE, WDATA, BRESP, RDATA.
REQ-013 IDLE: awready/arready SHALL be combinational, high only in IDLE for the granted channel; handshake moves to WDATA (write) or RDATA (read) next cycle.
REQ-014 Simultaneous awvalid and arvalid in IDLE SHALL be arbitrated round-robin; first grant after reset goes to write.
REQ-015 On AW/AR handshake SHALL latch id, len, start word index addr[MEM_AW+3:4], and an error flag.
REQ-016 Error flag SHALL be set if addr[ADDR_W-1:MEM_AW+4] != 0 or size != 3'd4; burst type SHALL be ignored and treated as INCR.
REQ-017 WDATA: wready SHALL be 1; each beat SHALL write RAM at current index with byte enables wstrb (byte i = bits 8i+7:8i), dropped if error flag set; index +1 per beat, wrapping modulo 2^MEM_AW.
REQ-018 WDATA SHALL end on beat number awlen+1 regardless of wlast; wlast absent on that beat or present earlier SHALL set error flag; next state BRESP.
REQ-019 BRESP: bvalid=1, bid=latched awid, bresp=2'b10 if error flag else 2'b00; held until bready, then IDLE.
REQ-020 RDATA: RAM read latency 1 cycle; a RAM read SHALL issue when beats remain and (!rvalid or rready), giving 1 beat/cycle under continuous rready.
REQ-021 rdata/rvalid/rlast/rresp SHALL stay stable while rvalid && !rready.
REQ-022 rid=latched arid; rlast=1 on beat arlen+1 only; rresp=2'b10 and rdata=0 for every beat if error flag set.
REQ-023 RDATA SHALL return to IDLE the cycle after handshake with rlast=1.
REQ-024 Writes SHALL be visible to any read accepted after the write's BRESP handshake.

Reset
REQ-025 On rst all ready/valid outputs, rlast, bresp, rresp, rdata, bid, rid SHALL be 0; FSM to IDLE; arbitration points to write; RAM contents undefined.
REQ-026 rst mid-burst SHALL abort the transaction with no response; in-flight write beats already accepted stay in RAM.

Structure
REQ-027 Shared package ddr_axi_pkg SHALL hold FSM state encoding, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, SIZE_16B=3'd4.
REQ-028 SHALL instantiate one sub-module ram_sdp_be_w128: simple dual-port RAM, 16 byte enables, registered 1-cycle read.

Verification
REQ-029 Write awaddr=0x100, awlen=3, wstrb=16'hffff, data 1..4; then read same, rready=1 -> bresp=0, 4 beats 1..4, rlast on beat 4 only.
REQ-030 Write awlen=0 wstrb=16'h0001 data 0xAB over word 0xFF..FF -> read returns 0xFF..FFAB.
REQ-031 awvalid and arvalid both high in IDLE twice in a row -> first write served, then read.
REQ-032 araddr=1<<(MEM_AW+4), arlen=1 -> 2 beats rresp=2'b10, rdata=0; awaddr same -> bresp=2'b10, RAM unchanged.
REQ-033 Read arlen=7 with rready toggled 1/0 each cycle -> 8 beats in order, rdata stable during stalls, 16 cycles to drain.
REQ-034 Write awlen=3 with wlast on beat 2 -> 4 beats accepted, bresp=2'b10; rst asserted mid-RDATA -> rvalid=0 next cycle, FSM IDLE.

Source files
------------

// File: rtl/ddr_axi_pkg.sv
// Shared definitions for the DDR AXI slave memory: FSM encoding, response
// codes and the only transfer size this memory accepts.
package ddr_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_BRESP = 2'd2,
    ST_RDATA = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_16B    = 3'd4;

  localparam int DATA_W = 128;
  localparam int STRB_W = DATA_W / 8;

  // Map the latched transaction error flag to the AXI response code.
  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/ddr_axi_slave_mem_if.sv
// AXI4 bus bundle for the DDR slave memory.
// Handshake rule on every channel: a transfer happens on the rising clk edge
// where valid && ready are both 1; once valid is raised the payload is held
// stable and valid stays high until that edge; ready may depend on valid.
interface ddr_axi_slave_mem_if #(
  parameter int ADDR_W = 49,
  parameter int ID_W   = 6
);
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [127:0]      wdata;
  logic [15:0]       wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [127:0]      rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/ram_sdp_be_w128.sv
// Simple dual-port 128-bit RAM: one byte-enabled write port, one read port
// with a registered output (data appears the cycle after re).
module ram_sdp_be_w128 #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [127:0]  wdata,
  input  logic [15:0]   wbe,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [127:0]  rdata
);

  logic [127:0] mem [0:(2**AW)-1];
  logic [127:0] rdata_q;

  // Byte-lane write: only lanes with their enable set are updated.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 16; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered read; output holds when re is low.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ddr_axi_slave_mem.sv
// AXI4 responder in front of a 2^MEM_AW x 128-bit RAM. One transaction at a
// time; bursts are always treated as INCR with 16-byte beats. Out-of-range
// addresses or other sizes answer SLVERR without touching the RAM.
module ddr_axi_slave_mem
  import ddr_axi_pkg::*;
#(
  parameter int ADDR_W = 49,
  parameter int MEM_AW = 10,
  parameter int ID_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [127:0]      s_axi_wdata,
  input  logic [15:0]       s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [127:0]      s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output state_e            dbg_state
);

  state_e              state_q, state_d;
  logic                prio_wr_q, prio_wr_d;   // 1: write wins a tie
  logic [ID_W-1:0]     id_q, id_d;
  logic [7:0]          len_q, len_d;
  logic [MEM_AW-1:0]   idx_q, idx_d;           // current RAM word index
  logic                err_q, err_d;
  logic [7:0]          beat_q, beat_d;         // write beats already taken
  logic [8:0]          rd_left_q, rd_left_d;   // read beats not yet issued
  logic                rvalid_q, rvalid_d;
  logic                rlast_q, rlast_d;
  logic [1:0]          rresp_q, rresp_d;

  logic                ram_we;
  logic [15:0]         ram_wbe;
  logic                ram_re;
  logic [127:0]        ram_rdata;

  logic idle, grant_wr, grant_rd;
  logic aw_hs, ar_hs, w_hs, r_hs, r_issue, w_last_beat;
  logic aw_bad, ar_bad;

  // Burst type and the byte offset inside a beat carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awburst, s_axi_arburst,
                       s_axi_awaddr[3:0], s_axi_araddr[3:0]};

  assign idle     = (state_q == ST_IDLE);
  assign grant_wr = s_axi_awvalid && (!s_axi_arvalid || prio_wr_q);
  assign grant_rd = s_axi_arvalid && !grant_wr;

  assign s_axi_awready = idle && grant_wr;
  assign s_axi_arready = idle && grant_rd;
  assign s_axi_wready  = (state_q == ST_WDATA);
  assign s_axi_bvalid  = (state_q == ST_BRESP);
  assign s_axi_bid     = id_q;
  assign s_axi_bresp   = s_axi_bvalid ? resp_of(err_q) : RESP_OKAY;
  assign s_axi_rid     = id_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rresp   = rresp_q;
  // RAM output only changes on a new read, so rdata holds during stalls.
  assign s_axi_rdata   = (rvalid_q && !err_q) ? ram_rdata : '0;
  assign dbg_state     = state_q;

  assign aw_hs       = s_axi_awvalid && s_axi_awready;
  assign ar_hs       = s_axi_arvalid && s_axi_arready;
  assign w_hs        = s_axi_wvalid && s_axi_wready;
  assign r_hs        = rvalid_q && s_axi_rready;
  assign w_last_beat = (beat_q == len_q);
  assign r_issue     = (state_q == ST_RDATA) && (rd_left_q != 9'd0) &&
                       (!rvalid_q || s_axi_rready);
  assign aw_bad      = (|(s_axi_awaddr >> (MEM_AW + 4))) || (s_axi_awsize != SIZE_16B);
  assign ar_bad      = (|(s_axi_araddr >> (MEM_AW + 4))) || (s_axi_arsize != SIZE_16B);

  // Next-state and datapath decisions for the transaction FSM.
  always_comb begin
    state_d   = state_q;
    prio_wr_d = prio_wr_q;
    id_d      = id_q;
    len_d     = len_q;
    idx_d     = idx_q;
    err_d     = err_q;
    beat_d    = beat_q;
    rd_left_d = rd_left_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    ram_we    = 1'b0;
    ram_wbe   = '0;
    ram_re    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (aw_hs) begin
          id_d      = s_axi_awid;
          len_d     = s_axi_awlen;
          idx_d     = s_axi_awaddr[MEM_AW+3:4];
          err_d     = aw_bad;
          beat_d    = 8'd0;
          prio_wr_d = 1'b0;
          state_d   = ST_WDATA;
        end else if (ar_hs) begin
          id_d      = s_axi_arid;
          len_d     = s_axi_arlen;
          idx_d     = s_axi_araddr[MEM_AW+3:4];
          err_d     = ar_bad;
          rd_left_d = {1'b0, s_axi_arlen} + 9'd1;
          prio_wr_d = 1'b1;
          state_d   = ST_RDATA;
        end
      end
      ST_WDATA: begin
        if (w_hs) begin
          ram_we  = !err_q && !rst;
          ram_wbe = s_axi_wstrb;
          idx_d   = idx_q + MEM_AW'(1);
          // Beat count decides the end; a wlast mismatch only flags an error.
          if (s_axi_wlast != w_last_beat) err_d = 1'b1;
          if (w_last_beat) state_d = ST_BRESP;
          else             beat_d  = beat_q + 8'd1;
        end
      end
      ST_BRESP: begin
        if (s_axi_bready) state_d = ST_IDLE;
      end
      ST_RDATA: begin
        if (r_issue) begin
          ram_re    = 1'b1;
          idx_d     = idx_q + MEM_AW'(1);
          rd_left_d = rd_left_q - 9'd1;
          rvalid_d  = 1'b1;
          rlast_d   = (rd_left_q == 9'd1);
          rresp_d   = resp_of(err_q);
        end else if (r_hs) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          rresp_d   = RESP_OKAY;
        end
        if (r_hs && rlast_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prio_wr_q <= 1'b1;
      id_q      <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      beat_q    <= '0;
      rd_left_q <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      id_q      <= id_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      beat_q    <= beat_d;
      rd_left_q <= rd_left_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
    end
  end

  ram_sdp_be_w128 #(.AW(MEM_AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (idx_q),
    .wdata (s_axi_wdata),
    .wbe   (ram_wbe),
    .re    (ram_re),
    .raddr (idx_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_ddr_axi_slave_mem.sv
// Directed plus randomized bench for ddr_axi_slave_mem against a word-array
// memory model.
module tb_ddr_axi_slave_mem;
  import ddr_axi_pkg::*;

  localparam int ADDR_W = 49;
  localparam int MEM_AW = 10;
  localparam int ID_W   = 6;
  localparam int DEPTH  = 1 << MEM_AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  state_e dbg_state;

  // Clock
  always #5 clk = ~clk;

  ddr_axi_slave_mem_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

  ddr_axi_slave_mem #(.ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(bus.awid), .s_axi_awaddr(bus.awaddr), .s_axi_awlen(bus.awlen),
    .s_axi_awsize(bus.awsize), .s_axi_awburst(bus.awburst),
    .s_axi_awvalid(bus.awvalid), .s_axi_awready(bus.awready),
    .s_axi_wdata(bus.wdata), .s_axi_wstrb(bus.wstrb), .s_axi_wlast(bus.wlast),
    .s_axi_wvalid(bus.wvalid), .s_axi_wready(bus.wready),
    .s_axi_bid(bus.bid), .s_axi_bresp(bus.bresp), .s_axi_bvalid(bus.bvalid),
    .s_axi_bready(bus.bready),
    .s_axi_arid(bus.arid), .s_axi_araddr(bus.araddr), .s_axi_arlen(bus.arlen),
    .s_axi_arsize(bus.arsize), .s_axi_arburst(bus.arburst),
    .s_axi_arvalid(bus.arvalid), .s_axi_arready(bus.arready),
    .s_axi_rid(bus.rid), .s_axi_rdata(bus.rdata), .s_axi_rresp(bus.rresp),
    .s_axi_rlast(bus.rlast), .s_axi_rvalid(bus.rvalid), .s_axi_rready(bus.rready),
    .dbg_state(dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [127:0] model_mem [0:DEPTH-1];
  logic [127:0] wd [0:255];
  logic [15:0]  ws [0:255];
  logic [127:0] exp_q [$];
  logic [127:0] got_d [$];
  logic         got_last [$];
  logic [1:0]   got_resp [$];
  logic [ID_W-1:0] got_id [$];
  int first_hs_cyc, last_hs_cyc;

  // Scoreboard compare
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a, input logic [2:0] sz);
    return ((a >> (MEM_AW + 4)) != 0) || (sz != 3'd4);
  endfunction

  // Reference model of a write burst; returns the response it should earn.
  task automatic model_write(input logic [ADDR_W-1:0] addr, input int len, input logic [2:0] size,
                             input int early_last, output logic [1:0] resp);
    logic err;
    int idx;
    logic lastb;
    err = addr_bad(addr, size);
    idx = int'((addr >> 4) % DEPTH);
    for (int b = 0; b <= len; b++) begin
      if (!err)
        for (int i = 0; i < 16; i++)
          if (ws[b][i]) model_mem[idx][8*i +: 8] = wd[b][8*i +: 8];
      lastb = (early_last >= 0) ? (b == early_last) : (b == len);
      if (lastb != (b == len)) err = 1'b1;
      idx = (idx + 1) % DEPTH;
    end
    resp = err ? 2'b10 : 2'b00;
  endtask

  // Driver: one write burst
  task automatic axi_write(input logic [ADDR_W-1:0] addr, input int len, input logic [2:0] size,
                           input logic [ID_W-1:0] id, input int early_last, output logic [1:0] resp);
    int n;
    bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len); bus.awsize = size;
    bus.awburst = 2'($urandom_range(0, 3)); bus.awvalid = 1'b1;
    #1;
    n = 0;
    while (!bus.awready && n < 50) begin tick(); #1; n++; end
    check("aw_wait", 128'(n < 50), 128'(1));
    tick();
    bus.awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      bus.wdata = wd[b]; bus.wstrb = ws[b];
      bus.wlast = (early_last >= 0) ? (b == early_last) : (b == len);
      bus.wvalid = 1'b1;
      #1;
      n = 0;
      while (!bus.wready && n < 50) begin tick(); #1; n++; end
      tick();
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
    #1;
    n = 0;
    while (!bus.bvalid && n < 50) begin tick(); #1; n++; end
    check("b_wait", 128'(bus.bvalid), 128'(1));
    resp = bus.bresp;
    check("bid", 128'(bus.bid), 128'(id));
    tick();
    bus.bready = 1'b0;
  endtask

  // Driver: one read burst; mode 0 rready=1, 1 alternating, 2 random
  task automatic axi_read(input logic [ADDR_W-1:0] addr, input int len, input logic [2:0] size,
                          input logic [ID_W-1:0] id, input int mode);
    int n, cyc;
    logic stalled, done;
    logic [127:0] hold_d;
    logic hold_l;
    logic [1:0] hold_r;
    got_d.delete(); got_last.delete(); got_resp.delete(); got_id.delete();
    bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len); bus.arsize = size;
    bus.arburst = 2'($urandom_range(0, 3)); bus.arvalid = 1'b1;
    #1;
    n = 0;
    while (!bus.arready && n < 50) begin tick(); #1; n++; end
    check("ar_wait", 128'(n < 50), 128'(1));
    tick();
    bus.arvalid = 1'b0;
    cyc = 0; stalled = 1'b0; done = 1'b0;
    hold_d = '0; hold_l = 1'b0; hold_r = '0;
    while (!done && cyc < 2000) begin
      bus.rready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      #1;
      if (stalled) begin
        check("r_hold_valid", 128'(bus.rvalid), 128'(1));
        check("r_hold_data", bus.rdata, hold_d);
        check("r_hold_last", 128'(bus.rlast), 128'(hold_l));
        check("r_hold_resp", 128'(bus.rresp), 128'(hold_r));
      end
      if (bus.rvalid && bus.rready) begin
        got_d.push_back(bus.rdata); got_last.push_back(bus.rlast);
        got_resp.push_back(bus.rresp); got_id.push_back(bus.rid);
        if (got_d.size() == 1) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        if (bus.rlast || got_d.size() > len) done = 1'b1;
        stalled = 1'b0;
      end else if (bus.rvalid) begin
        stalled = 1'b1; hold_d = bus.rdata; hold_l = bus.rlast; hold_r = bus.rresp;
      end else begin
        stalled = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.rready = 1'b0;
    check("r_done", 128'(done), 128'(1));
    check("r_back_idle", 128'(dbg_state), 128'(ST_IDLE));
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input int len, input logic [2:0] size,
                          input int early_last);
    logic [1:0] exp_resp, resp;
    logic [ID_W-1:0] id;
    id = ID_W'($urandom_range(0, 63));
    model_write(addr, len, size, early_last, exp_resp);
    axi_write(addr, len, size, id, early_last, resp);
    check("bresp", 128'(resp), 128'(exp_resp));
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input int len, input logic [2:0] size,
                         input int mode);
    logic [ID_W-1:0] id;
    logic err;
    int idx;
    id = ID_W'($urandom_range(0, 63));
    err = addr_bad(addr, size);
    idx = int'((addr >> 4) % DEPTH);
    exp_q.delete();
    for (int b = 0; b <= len; b++) exp_q.push_back(err ? 128'd0 : model_mem[(idx + b) % DEPTH]);
    axi_read(addr, len, size, id, mode);
    check("r_beats", 128'(got_d.size()), 128'(len + 1));
    for (int b = 0; b < got_d.size() && b <= len; b++) begin
      check("rdata", got_d[b], exp_q[b]);
      check("rresp", 128'(got_resp[b]), err ? 128'(2) : 128'(0));
      check("rlast", 128'(got_last[b]), 128'(b == len));
      check("rid", 128'(got_id[b]), 128'(id));
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    int ln, n;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_awready", 128'(bus.awready), 128'(0));
    check("rst_arready", 128'(bus.arready), 128'(0));
    check("rst_wready", 128'(bus.wready), 128'(0));
    check("rst_bvalid", 128'(bus.bvalid), 128'(0));
    check("rst_rvalid", 128'(bus.rvalid), 128'(0));
    check("rst_rlast", 128'(bus.rlast), 128'(0));
    check("rst_bresp", 128'(bus.bresp), 128'(0));
    check("rst_rresp", 128'(bus.rresp), 128'(0));
    check("rst_rdata", bus.rdata, 128'(0));
    check("rst_bid", 128'(bus.bid), 128'(0));
    check("rst_rid", 128'(bus.rid), 128'(0));
    check("rst_state", 128'(dbg_state), 128'(ST_IDLE));
    rst = 1'b0;
    tick();

    // Fill the whole RAM so every later read has a known expectation
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 256; b++) begin
        wd[b] = {$urandom, $urandom, $urandom, $urandom}; ws[b] = 16'hffff;
      end
      do_write(ADDR_W'(k * 256 * 16), 255, 3'd4, -1);
    end

    // Basic 4-beat write/read, back-to-back beats
    for (int b = 0; b < 4; b++) begin wd[b] = 128'(b + 1); ws[b] = 16'hffff; end
    do_write(ADDR_W'(32'h100), 3, 3'd4, -1);
    do_read(ADDR_W'(32'h100), 3, 3'd4, 0);
    check("burst_gap", 128'(last_hs_cyc - first_hs_cyc), 128'(3));

    // Single-byte strobe over all-ones word
    wd[0] = '1; ws[0] = 16'hffff;
    do_write(ADDR_W'(32'h200), 0, 3'd4, -1);
    wd[0] = 128'hAB; ws[0] = 16'h0001;
    do_write(ADDR_W'(32'h200), 0, 3'd4, -1);
    do_read(ADDR_W'(32'h200), 0, 3'd4, 0);
    check("strobe_byte", got_d[0], {{15{8'hFF}}, 8'hAB});

    // Out-of-range address and wrong size
    do_read(ADDR_W'(1) << (MEM_AW + 4), 1, 3'd4, 0);
    for (int b = 0; b < 2; b++) begin wd[b] = '1; ws[b] = 16'hffff; end
    do_write(ADDR_W'(1) << (MEM_AW + 4), 1, 3'd4, -1);
    do_read(ADDR_W'(0), 1, 3'd4, 0);
    do_write(ADDR_W'(32'h300), 1, 3'd3, -1);
    do_read(ADDR_W'(32'h300), 1, 3'd3, 0);
    do_read(ADDR_W'(32'h300), 1, 3'd4, 0);

    // Alternating rready: one beat every other cycle, data held in stalls
    do_read(ADDR_W'(32'h1000), 7, 3'd4, 1);
    check("toggle_gap", 128'(last_hs_cyc - first_hs_cyc), 128'(14));

    // Early wlast on beat 2 of 4
    for (int b = 0; b < 4; b++) begin wd[b] = {$urandom, $urandom, $urandom, $urandom}; ws[b] = 16'hffff; end
    do_write(ADDR_W'(32'h400), 3, 3'd4, 1);
    do_read(ADDR_W'(32'h400), 3, 3'd4, 0);

    // Index wraps at the top of the RAM
    for (int b = 0; b < 3; b++) begin wd[b] = {$urandom, $urandom, $urandom, $urandom}; ws[b] = 16'hffff; end
    do_write(ADDR_W'(DEPTH - 1) << 4, 2, 3'd4, -1);
    do_read(ADDR_W'(DEPTH - 1) << 4, 2, 3'd4, 2);

    // Randomized traffic
    for (int t = 0; t < 24; t++) begin
      a = ADDR_W'($urandom_range(0, DEPTH - 1)) << 4 | ADDR_W'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = a | (ADDR_W'(1) << $urandom_range(MEM_AW + 4, ADDR_W - 1));
      ln = $urandom_range(0, 7);
      for (int b = 0; b <= ln; b++) begin
        wd[b] = {$urandom, $urandom, $urandom, $urandom}; ws[b] = 16'($urandom);
      end
      do_write(a, ln, 3'd4, -1);
      do_read(a, ln, 3'd4, 2);
    end

    // Reset in the middle of a read burst
    bus.arid = 6'd5; bus.araddr = '0; bus.arlen = 8'd7; bus.arsize = 3'd4; bus.arvalid = 1'b1;
    bus.rready = 1'b0;
    #1;
    n = 0;
    while (!bus.arready && n < 50) begin tick(); #1; n++; end
    tick();
    bus.arvalid = 1'b0;
    repeat (3) tick();
    check("midrd_rvalid", 128'(bus.rvalid), 128'(1));
    rst = 1'b1;
    tick();
    check("midrd_rst_rvalid", 128'(bus.rvalid), 128'(0));
    check("midrd_rst_state", 128'(dbg_state), 128'(ST_IDLE));
    check("midrd_rst_rlast", 128'(bus.rlast), 128'(0));
    check("midrd_rst_rdata", bus.rdata, 128'(0));
    rst = 1'b0;
    tick();

    // Simultaneous AW/AR after reset: write first, then read
    bus.arid = 6'd9; bus.araddr = ADDR_W'(32'h500); bus.arlen = 8'd0; bus.arsize = 3'd4;
    bus.arvalid = 1'b1;
    bus.awid = 6'd3; bus.awaddr = ADDR_W'(32'h500); bus.awlen = 8'd0; bus.awsize = 3'd4;
    bus.awvalid = 1'b1;
    #1;
    check("rr1_awready", 128'(bus.awready), 128'(1));
    check("rr1_arready", 128'(bus.arready), 128'(0));
    wd[0] = {$urandom, $urandom, $urandom, $urandom}; ws[0] = 16'hffff;
    do_write(ADDR_W'(32'h500), 0, 3'd4, -1);
    bus.awvalid = 1'b1;
    #1;
    check("rr2_arready", 128'(bus.arready), 128'(1));
    check("rr2_awready", 128'(bus.awready), 128'(0));
    bus.awvalid = 1'b0;
    do_read(ADDR_W'(32'h500), 0, 3'd4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
